// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch (I) and data (D) pipeline ports.
// Latency: request seen in IDLE cycle t, mem_ack at t+1+k -> *_done at t+2+k; next grant no earlier than t+3+k.
// Backpressure: one access in flight; stall_f/stall_m freeze each stage until its own done pulse.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_done,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_f,
   output logic                stall_m,
   output logic                err
);

   // Watchdog only needs to reach TIMEOUT-1; keep at least one bit so TIMEOUT of 0 or 1 still elaborates.
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state;
   logic            last_grant_d;   // 0 = fetch port was granted last, 1 = data port
   logic [WD_W-1:0] watchdog;
   logic            wd_expired;
   logic            grant_i;
   logic            grant_d;

   // A lone requester wins outright; a tie goes to the port that did not win last time.
   assign grant_d = d_req & (~i_req | ~last_grant_d);
   assign grant_i = i_req & (~d_req |  last_grant_d);

   assign wd_expired = (TIMEOUT != 0) && (watchdog == WD_W'(TIMEOUT - 1));

   // Stage stalls drop in the same cycle as the stage's own done pulse.
   assign stall_f = i_req & ~i_done;
   assign stall_m = d_req & ~d_done;

   // Arbitration FSM: grant, hold the bus until ack or watchdog expiry, then one DONE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         last_grant_d <= 1'b0;
         watchdog     <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_be       <= '0;
         i_rdata      <= '0;
         d_rdata      <= '0;
         i_done       <= 1'b0;
         d_done       <= 1'b0;
         err          <= 1'b0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               watchdog <= '0;
               if (grant_d) begin
                  mem_req      <= 1'b1;
                  mem_we       <= d_we;
                  mem_addr     <= d_addr;
                  mem_wdata    <= d_wdata;
                  mem_be       <= d_be;
                  last_grant_d <= 1'b1;
                  state        <= D_BUSY;
               end else if (grant_i) begin
                  mem_req      <= 1'b1;
                  mem_we       <= 1'b0;
                  mem_addr     <= i_addr;
                  mem_wdata    <= '0;
                  mem_be       <= '1;
                  last_grant_d <= 1'b0;
                  state        <= I_BUSY;
               end
            end
            I_BUSY, D_BUSY: begin
               if (mem_ack) begin
                  // A late ack on the watchdog's final cycle still counts as a normal completion.
                  mem_req <= 1'b0;
                  state   <= DONE;
                  if (state == I_BUSY) begin
                     i_done  <= 1'b1;
                     i_rdata <= mem_rdata;
                  end else begin
                     d_done <= 1'b1;
                     if (!mem_we) begin
                        d_rdata <= mem_rdata;
                     end
                  end
               end else if (wd_expired) begin
                  mem_req <= 1'b0;
                  state   <= DONE;
                  err     <= 1'b1;
                  if (state == I_BUSY) begin
                     i_done  <= 1'b1;
                     i_rdata <= '0;
                  end else begin
                     d_done  <= 1'b1;
                     d_rdata <= '0;
                  end
               end else begin
                  watchdog <= watchdog + WD_W'(1);
               end
            end
            DONE: begin
               watchdog <= '0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks for mem_arbiter with a behavioural memory responder and reference model.
// Latency: responder acks k cycles after mem_req rises; k chosen per access by the bench.
// Backpressure: request ports hold their level until the matching done pulse.
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall_f;
   logic        stall_m;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   int          ack_delay = 0;
   bit          ack_mute = 0;
   int          resp_cnt = 0;
   logic [31:0] mem_model [16];   // memory contents as written through the DUT bus
   logic [31:0] ref_mem   [16];   // memory contents the bench predicts
   bit          model_last_d = 0;
   logic [31:0] exp_ird = '0;
   logic [31:0] exp_drd = '0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_f(stall_f), .stall_m(stall_m), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] apply_be(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   // Memory responder: acks ack_delay cycles after mem_req is first seen high.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (!mem_req) begin
            resp_cnt = 0;
         end else if (!ack_mute && resp_cnt >= ack_delay) begin
            mem_ack  = 1'b1;
            resp_cnt = 0;
            if (mem_we) begin
               mem_model[mem_addr[5:2]] = apply_be(mem_model[mem_addr[5:2]], mem_wdata, mem_be);
               mem_rdata = $urandom;
            end else begin
               mem_rdata = mem_model[mem_addr[5:2]];
            end
         end else begin
            resp_cnt++;
         end
      end
   end

   task automatic rand_i();
      i_addr = $urandom & 32'hFFFF_FFFC;
   endtask

   task automatic rand_d();
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_we    = 1'($urandom);
      d_wdata = $urandom;
      d_be    = 4'($urandom);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, i_done, d_done, err, stall_f, stall_m} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0000000", {mem_req, mem_we, i_done, d_done, err, stall_f, stall_m});
      end
      checks++;
      if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
      checks++;
      if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h required 0", mem_wdata); end
      checks++;
      if (mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_be: got %h required 0", mem_be); end
      checks++;
      if (i_rdata !== 32'h0) begin errors++; $display("FAIL reset_i_rdata: got %h required 0", i_rdata); end
      checks++;
      if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h required 0", d_rdata); end
   endtask

   task automatic test_fetch();
      int n;
      mem_model[4] = 32'h2402_0005;
      ref_mem[4]   = 32'h2402_0005;
      ack_delay = 1;
      i_addr = 32'h0000_0010;
      i_req  = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (mem_req) begin
            checks++;
            if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, 32'h0000_0010}) begin
               errors++;
               $display("FAIL fetch_bus: we/be/addr got %b/%h/%h required 0/f/00000010", mem_we, mem_be, mem_addr);
            end
         end
      end while (!i_done && n < 20);
      checks++;
      if (i_done !== 1'b1 || n != 3) begin errors++; $display("FAIL fetch_latency: i_done=%b after %0d cycles, required 1 after 3", i_done, n); end
      exp_ird = 32'h2402_0005;
      checks++;
      if (i_rdata !== exp_ird) begin errors++; $display("FAIL fetch_rdata: got %h required %h", i_rdata, exp_ird); end
      checks++;
      if (stall_f !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL fetch_stall_err: stall_f=%b err=%b required 0 0", stall_f, err); end
      i_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({i_done, err, mem_req} !== 3'b000) begin errors++; $display("FAIL fetch_pulse: done/err/req got %b required 000", {i_done, err, mem_req}); end
      checks++;
      if (i_rdata !== exp_ird) begin errors++; $display("FAIL fetch_hold: got %h required %h", i_rdata, exp_ird); end
      model_last_d = 1'b0;
   endtask

   task automatic test_priority();
      int n;
      ack_delay = 0;
      d_addr = 32'h0000_0020; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
      i_addr = 32'h0000_0024;
      i_req = 1'b1; d_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!i_done && !d_done && n < 20);
      checks++;
      if ({d_done, i_done} !== 2'b10 || n != 2) begin errors++; $display("FAIL prio_first: d/i done %b after %0d, required 10 after 2", {d_done, i_done}, n); end
      exp_drd = ref_mem[8];
      checks++;
      if (d_rdata !== exp_drd) begin errors++; $display("FAIL prio_d_rdata: got %h required %h", d_rdata, exp_drd); end
      checks++;
      if ({stall_f, stall_m} !== 2'b10) begin errors++; $display("FAIL prio_stall: f/m got %b required 10", {stall_f, stall_m}); end
      d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL prio_idle: mem_req=%b required 0", mem_req); end
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0024) begin errors++; $display("FAIL prio_second: req=%b addr=%h required 1 00000024", mem_req, mem_addr); end
      n = 0;
      while (!i_done && n < 20) begin @(negedge clk); n++; end
      exp_ird = ref_mem[9];
      checks++;
      if (i_done !== 1'b1 || i_rdata !== exp_ird) begin errors++; $display("FAIL prio_i: done=%b rdata=%h required 1 %h", i_done, i_rdata, exp_ird); end
      i_req = 1'b0;
      model_last_d = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store();
      int n;
      logic [31:0] expect_word;
      expect_word = apply_be(ref_mem[0], 32'hDEAD_BEEF, 4'b0011);
      ack_delay = 2;
      d_addr = 32'h0000_0100; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
      d_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (mem_req) begin
            checks++;
            if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011}) begin
               errors++;
               $display("FAIL store_bus: we/addr/wdata/be got %b/%h/%h/%h required 1/00000100/deadbeef/3", mem_we, mem_addr, mem_wdata, mem_be);
            end
         end
      end while (!d_done && n < 20);
      checks++;
      if (d_done !== 1'b1 || n != 4 || err !== 1'b0) begin errors++; $display("FAIL store_done: done=%b err=%b after %0d, required 1 0 after 4", d_done, err, n); end
      checks++;
      if (d_rdata !== exp_drd) begin errors++; $display("FAIL store_rdata_hold: got %h required %h", d_rdata, exp_drd); end
      ref_mem[0] = expect_word;
      checks++;
      if (mem_model[0] !== expect_word) begin errors++; $display("FAIL store_bytes: memory got %h required %h", mem_model[0], expect_word); end
      d_req = 1'b0; d_we = 1'b0;
      model_last_d = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alternate();
      bit          exp_d;
      int          n;
      int          k;
      logic [36:0] exp_bus;
      rand_i(); rand_d();
      i_req = 1'b1; d_req = 1'b1;
      for (int t = 0; t < 20; t++) begin
         exp_d = (i_req && d_req) ? !model_last_d : d_req;
         k = $urandom_range(0, 3);
         ack_delay = k;
         n = 0;
         do begin @(negedge clk); n++; end while (!mem_req && n < 10);
         checks++;
         if (mem_req !== 1'b1 || n != ((t == 0) ? 1 : 2)) begin
            errors++;
            $display("FAIL alt_gap[%0d]: mem_req=%b after %0d, required 1 after %0d", t, mem_req, n, (t == 0) ? 1 : 2);
         end
         exp_bus = exp_d ? {d_we, d_addr, d_be} : {1'b0, i_addr, 4'hF};
         checks++;
         if ({mem_we, mem_addr, mem_be} !== exp_bus) begin errors++; $display("FAIL alt_bus[%0d]: got %h required %h", t, {mem_we, mem_addr, mem_be}, exp_bus); end
         if (exp_d && d_we) begin
            checks++;
            if (mem_wdata !== d_wdata) begin errors++; $display("FAIL alt_wdata[%0d]: got %h required %h", t, mem_wdata, d_wdata); end
         end
         n = 0;
         do begin @(negedge clk); n++; end while (!i_done && !d_done && n < 10);
         checks++;
         if ({i_done, d_done, err} !== (exp_d ? 3'b010 : 3'b100) || n != k + 1) begin
            errors++;
            $display("FAIL alt_done[%0d]: i/d/err %b after %0d, required %b after %0d", t, {i_done, d_done, err}, n, exp_d ? 3'b010 : 3'b100, k + 1);
         end
         checks++;
         if ({stall_f, stall_m} !== (exp_d ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_stall[%0d]: f/m got %b required %b", t, {stall_f, stall_m}, exp_d ? 2'b10 : 2'b01); end
         if (exp_d) begin
            if (d_we) ref_mem[d_addr[5:2]] = apply_be(ref_mem[d_addr[5:2]], d_wdata, d_be);
            else exp_drd = ref_mem[d_addr[5:2]];
            checks++;
            if (d_rdata !== exp_drd) begin errors++; $display("FAIL alt_d_rdata[%0d]: got %h required %h", t, d_rdata, exp_drd); end
            rand_d();
         end else begin
            exp_ird = ref_mem[i_addr[5:2]];
            checks++;
            if (i_rdata !== exp_ird) begin errors++; $display("FAIL alt_i_rdata[%0d]: got %h required %h", t, i_rdata, exp_ird); end
            rand_i();
         end
         model_last_d = exp_d;
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      for (int j = 0; j < 16; j++) begin
         checks++;
         if (mem_model[j] !== ref_mem[j]) begin errors++; $display("FAIL alt_mem[%0d]: got %h required %h", j, mem_model[j], ref_mem[j]); end
      end
   endtask

   task automatic test_timeout();
      int n;
      int hi;
      ack_mute = 1'b1;
      d_addr = 32'h0000_0040; d_we = 1'b0; d_be = 4'hF;
      d_req = 1'b1;
      n = 0; hi = 0;
      do begin
         @(negedge clk);
         n++;
         if (mem_req) hi++;
      end while (!d_done && n < 30);
      checks++;
      if ({d_done, err, i_done} !== 3'b110) begin errors++; $display("FAIL timeout_pulse: d_done/err/i_done got %b required 110", {d_done, err, i_done}); end
      checks++;
      if (hi != TO) begin errors++; $display("FAIL timeout_req_cycles: got %0d required %0d", hi, TO); end
      exp_drd = '0;
      checks++;
      if (d_rdata !== exp_drd) begin errors++; $display("FAIL timeout_rdata: got %h required 0", d_rdata); end
      d_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({d_done, err, mem_req} !== 3'b000) begin errors++; $display("FAIL timeout_clear: done/err/req got %b required 000", {d_done, err, mem_req}); end
      ack_mute = 1'b0;
      model_last_d = 1'b1;
   endtask

   task automatic test_reset_mid();
      int  n;
      bit  exp_d;
      ack_mute = 1'b1;
      d_addr = 32'h0000_0008; d_we = 1'b1; d_wdata = 32'h1234_5678; d_be = 4'hF;
      d_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_req && n < 10);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_async: mem_req=%b required 0", mem_req); end
      d_req = 1'b0;
      ack_mute = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_last_d = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, i_done, d_done, err} !== 73'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h required 0", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, i_done, d_done, err});
      end
      checks++;
      if ({i_rdata, d_rdata} !== 64'b0) begin errors++; $display("FAIL reset_mid_rdata: got %h required 0", {i_rdata, d_rdata}); end
      ack_delay = 0;
      i_addr = 32'h0000_000C; i_req = 1'b1; d_req = 1'b1;
      exp_d = !model_last_d;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_req && n < 10);
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, exp_d ? 1'b1 : 1'b0, exp_d ? 32'h0000_0008 : 32'h0000_000C}) begin
         errors++;
         $display("FAIL reset_mid_grant: req/we/addr got %b/%b/%h required 1/%b/%h", mem_req, mem_we, mem_addr, exp_d, exp_d ? 32'h8 : 32'hC);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!i_done && !d_done && n < 10);
      checks++;
      if (d_done !== exp_d || i_done !== !exp_d) begin errors++; $display("FAIL reset_mid_done: d/i got %b required %b", {d_done, i_done}, {exp_d, !exp_d}); end
      i_req = 1'b0; d_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
      for (int j = 0; j < 16; j++) begin
         mem_model[j] = $urandom;
         ref_mem[j]   = mem_model[j];
      end
      test_reset();
      test_fetch();
      test_priority();
      test_store();
      test_alternate();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL sim_time_limit: run did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "time limit");
   end

endmodule
